udp_tx_framer: RTL and testbench

UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

---
 rtl/udp_tx_framer.sv | 224 ++++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// GMII UDP/IPv4 frame transmitter: builds Ethernet/IP/UDP headers around a RAM payload.
// Optional CRC-32 frame check sequence is enabled by defining UDP_TX_FCS_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for tx_start, outputs quiet
// S_CALC     | 2 cycles: IP header checksum accumulate, then fold/invert
// S_PREAMBLE | 7 x 0x55 then SFD 0xD5
// S_ETH_HDR  | destination MAC, source MAC, EtherType 0x0800
// S_IP_HDR   | 20-byte IPv4 header
// S_UDP_HDR  | ports, UDP length, zero checksum; payload address 0 prefetched here
// S_PAYLOAD  | len bytes streamed from the payload RAM
// S_PAD      | zero fill up to the 18-byte minimum payload
// S_FCS      | 4 CRC bytes, least significant first (UDP_TX_FCS_EN only)
// S_IFG      | 12 quiet cycles, tx_done on the last one
module udp_tx_framer #(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [31:0] DEST_IP    = 32'hC0A8_0003,
  parameter logic [15:0] LOCAL_PORT = 16'd8080,
  parameter logic [15:0] DEST_PORT  = 16'd8080,
  parameter int          MAX_LEN    = 1472
) (
  input  logic        gmii_tx_clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [10:0] udp_send_ram_addr,
  input  logic [7:0]  udp_send_ram_rdata,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD,
`ifdef UDP_TX_FCS_EN
    S_FCS,
`endif
    S_IFG
  } state_t;

`ifdef UDP_TX_FCS_EN
  localparam state_t S_TAIL = S_FCS;
`else
  localparam state_t S_TAIL = S_IFG;
`endif
  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_c;
  logic [4:0]  pad_q, pad_c;
  logic [15:0] ip_id_q;
  logic [19:0] csum_acc_q, csum_acc_d;
  logic [15:0] csum_q;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;
  logic [10:0] addr_q, addr_d, addr_off;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, busy_q, done_q;
  logic [15:0] tot_len, udp_len;
  logic [111:0] eth_v;
  logic [159:0] ip_v;
  logic [63:0]  udp_v;
  logic [7:0]  eth_b [16];
  logic [7:0]  ip_b  [32];
  logic [7:0]  udp_b [8];

  assign len_c   = (tx_len > MAX_LEN_C) ? MAX_LEN_C : tx_len;
  assign pad_c   = (len_c < 11'd18) ? 5'(11'd18 - len_c) : 5'd0;
  assign tot_len = 16'(len_q) + 16'd28;
  assign udp_len = 16'(len_q) + 16'd8;

  assign csum_acc_d = 20'h04500 + 20'(tot_len) + 20'(ip_id_q) + 20'h04000 + 20'h04011
                    + 20'(LOCAL_IP[31:16]) + 20'(LOCAL_IP[15:0])
                    + 20'(DEST_IP[31:16]) + 20'(DEST_IP[15:0]);
  assign csum_f1 = 17'(csum_acc_q[15:0]) + 17'(csum_acc_q[19:16]);
  assign csum_f2 = csum_f1[15:0] + 16'(csum_f1[16]);

  assign eth_v = {DEST_MAC, LOCAL_MAC, 16'h0800};
  assign ip_v  = {16'h4500, tot_len, ip_id_q, 16'h4000, 8'h40, 8'h11, csum_q, LOCAL_IP, DEST_IP};
  assign udp_v = {LOCAL_PORT, DEST_PORT, udp_len, 16'h0000};

  always_comb begin
    for (int i = 0; i < 16; i++) eth_b[i] = 8'h00;
    for (int i = 0; i < 32; i++) ip_b[i] = 8'h00;
    for (int i = 0; i < 14; i++) eth_b[i] = eth_v[8*(13-i) +: 8];
    for (int i = 0; i < 20; i++) ip_b[i] = ip_v[8*(19-i) +: 8];
    for (int i = 0; i < 8; i++) udp_b[i] = udp_v[8*(7-i) +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_start) state_d = S_CALC;
      end
      S_CALC:     if (cnt_q == 11'd1)  begin state_d = S_PREAMBLE; cnt_d = '0; end
      S_PREAMBLE: if (cnt_q == 11'd7)  begin state_d = S_ETH_HDR;  cnt_d = '0; end
      S_ETH_HDR:  if (cnt_q == 11'd13) begin state_d = S_IP_HDR;   cnt_d = '0; end
      S_IP_HDR:   if (cnt_q == 11'd19) begin state_d = S_UDP_HDR;  cnt_d = '0; end
      S_UDP_HDR: if (cnt_q == 11'd7) begin
        state_d = (len_q != 11'd0) ? S_PAYLOAD : S_PAD;
        cnt_d   = '0;
      end
      S_PAYLOAD: if (cnt_q == len_q - 11'd1) begin
        state_d = (pad_q != 5'd0) ? S_PAD : S_TAIL;
        cnt_d   = '0;
      end
      S_PAD: if (cnt_q == 11'(pad_q) - 11'd1) begin state_d = S_TAIL; cnt_d = '0; end
`ifdef UDP_TX_FCS_EN
      S_FCS: if (cnt_q == 11'd3) begin state_d = S_IFG; cnt_d = '0; end
`endif
      S_IFG: if (cnt_q == 11'd11) begin state_d = S_IDLE; cnt_d = '0; end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase
  end

`ifdef UDP_TX_FCS_EN
  logic [31:0] crc_q, crc_d, fcs_v;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign fcs_v = ~crc_q;
`endif

  // Outputs are registered from the next state so each byte lands in the cycle of its state.
  always_comb begin
    txd_d = 8'h00;
    en_d  = 1'b0;
    case (state_d)
      S_PREAMBLE: begin en_d = 1'b1; txd_d = (cnt_d == 11'd7) ? 8'hD5 : 8'h55; end
      S_ETH_HDR:  begin en_d = 1'b1; txd_d = eth_b[cnt_d[3:0]]; end
      S_IP_HDR:   begin en_d = 1'b1; txd_d = ip_b[cnt_d[4:0]]; end
      S_UDP_HDR:  begin en_d = 1'b1; txd_d = udp_b[cnt_d[2:0]]; end
      S_PAYLOAD:  begin en_d = 1'b1; txd_d = udp_send_ram_rdata; end
      S_PAD:      en_d = 1'b1;
`ifdef UDP_TX_FCS_EN
      S_FCS: begin
        en_d  = 1'b1;
        txd_d = fcs_v[8*cnt_d[1:0] +: 8];
      end
`endif
      default: ;
    endcase
  end

`ifdef UDP_TX_FCS_EN
  always_comb begin
    crc_d = crc_q;
    if (state_d == S_PREAMBLE) crc_d = 32'hFFFF_FFFF;
    else if (en_d && state_d != S_TAIL) crc_d = crc_byte(crc_q, txd_d);
  end
`endif

  // Address runs two bytes ahead of the output to absorb the RAM read and output register.
  always_comb begin
    addr_d   = addr_q;
    addr_off = '0;
    if (state_d == S_IDLE) begin
      addr_d = '0;
    end else if ((state_d == S_UDP_HDR && cnt_d >= 11'd6) || state_d == S_PAYLOAD) begin
      addr_off = (state_d == S_PAYLOAD) ? cnt_d + 11'd2 : cnt_d - 11'd6;
      if (len_q != 11'd0) addr_d = (addr_off >= len_q) ? len_q - 11'd1 : addr_off;
    end
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      pad_q      <= '0;
      ip_id_q    <= '0;
      csum_acc_q <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
      txd_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UDP_TX_FCS_EN
      crc_q      <= '1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && tx_start) begin
        len_q <= len_c;
        pad_q <= pad_c;
      end
      if (state_q == S_CALC) begin
        if (cnt_q == 11'd0) csum_acc_q <= csum_acc_d;
        else csum_q <= ~csum_f2;
      end
      addr_q <= addr_d;
      txd_q  <= txd_d;
      en_q   <= en_d;
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_IFG && cnt_d == 11'd11);
      if (state_d == S_IFG && cnt_d == 11'd11) ip_id_q <= ip_id_q + 16'd1;
`ifdef UDP_TX_FCS_EN
      crc_q <= crc_d;
`endif
    end
  end

  assign gmii_txd          = txd_q;
  assign gmii_tx_en        = en_q;
  assign tx_busy           = busy_q;
  assign tx_done           = done_q;
  assign udp_send_ram_addr = addr_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed bench for udp_tx_framer: a byte-queue frame model is compared against GMII every cycle.
module tb_udp_tx_framer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] tx_len = '0;
  logic        tx_busy, tx_done, gmii_tx_en;
  logic [10:0] ram_addr;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  gmii_txd;

`ifdef UDP_TX_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  always #4 clk = ~clk;

  udp_tx_framer dut (
    .gmii_tx_clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .tx_busy(tx_busy), .tx_done(tx_done), .udp_send_ram_addr(ram_addr),
    .udp_send_ram_rdata(ram_rdata), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd)
  );

  logic [7:0] mem [0:2047];
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: the complete expected wire byte sequence for one frame.
  logic [7:0] exp_q[$];

  function automatic logic [31:0] crc32(input logic [7:0] d[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c ^= {24'd0, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push16(input int w);
    exp_q.push_back(8'((w >> 8) & 255));
    exp_q.push_back(8'(w & 255));
  endtask

  task automatic build_frame(input int len, input int id);
    int w[10];
    int sum;
    logic [47:0] dmac = 48'hFF_FF_FF_FF_FF_FF;
    logic [47:0] smac = 48'h00_0A_35_01_FE_C0;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(smac[8*i +: 8]);
    push16('h0800);
    w = '{'h4500, 28 + len, id, 'h4000, 'h4011, 0, 'hC0A8, 'h0002, 'hC0A8, 'h0003};
    sum = 0;
    foreach (w[i]) sum += w[i];
    while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
    w[5] = (~sum) & 'hFFFF;
    foreach (w[i]) push16(w[i]);
    push16(8080); push16(8080); push16(8 + len); push16(0);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
    for (int i = len; i < 18; i++) exp_q.push_back(8'h00);
`ifdef UDP_TX_FCS_EN
    begin
      logic [7:0] body[$];
      logic [31:0] fcs;
      body = exp_q[8:$];
      fcs = ~crc32(body);
      for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    end
`endif
  endtask

  int first_en, last_en, en_cnt, done_cnt, done_cyc, max_addr, pos;
  bit seen_en;

  always @(negedge clk) begin
    if (!rst) begin
      if (gmii_tx_en) begin
        if (!seen_en) first_en = cyc;
        seen_en = 1'b1;
        last_en = cyc;
        en_cnt++;
        if (exp_q.size() == 0) check("extra_byte", {24'd0, gmii_txd}, 32'hFFFF_FFFF);
        else check($sformatf("txd[%0d]", pos), {24'd0, gmii_txd}, {24'd0, exp_q.pop_front()});
        pos++;
      end else begin
        check("idle_txd", {24'd0, gmii_txd}, 0);
      end
      if (tx_done) begin done_cnt++; done_cyc = cyc; end
      if (tx_busy && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
    end
  end

  task automatic clear_track();
    seen_en = 1'b0; en_cnt = 0; done_cnt = 0; max_addr = 0; pos = 0;
    first_en = -1; last_en = -1; done_cyc = -1;
  endtask

  task automatic start_frame(input int len_in, output int st);
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 11'(len_in); st = cyc;
    @(negedge clk); check("busy_before_accept", {31'd0, tx_busy}, 0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk); check("busy_after_accept", {31'd0, tx_busy}, 1);
  endtask

  task automatic run_frame(input int len_in, input int id, input bit mid_pulse);
    int eff, st;
    bit got;
    eff = (len_in > 1472) ? 1472 : len_in;
    build_frame(eff, id);
    clear_track();
    start_frame(len_in, st);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (mid_pulse && i == 40) tx_start = 1'b1;
      else if (mid_pulse && i == 41) tx_start = 1'b0;
      if (tx_done) got = 1'b1;
    end
    tx_start = 1'b0;
    #1;
    check("done_seen", {31'd0, got}, 1);
    check("first_en_latency", first_en, st + 3);
    check("tx_en_cycles", en_cnt, 50 + ((eff > 18) ? eff : 18) + FCS_N);
    check("tx_en_contiguous", last_en - first_en + 1, en_cnt);
    check("done_after_ifg", done_cyc, last_en + 12);
    check("done_count", done_cnt, 1);
    check("bytes_left", exp_q.size(), 0);
    check("busy_at_done", {31'd0, tx_busy}, 1);
    check("max_addr", max_addr, (eff > 0) ? eff - 1 : 0);
  endtask

  initial begin
    int st;
    for (int i = 0; i < 2048; i++) mem[i] = 8'((i * 7 + 3) & 255);
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    clear_track();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_en", {31'd0, gmii_tx_en}, 0);
    check("rst_txd", {24'd0, gmii_txd}, 0);
    check("rst_busy", {31'd0, tx_busy}, 0);
    check("rst_done", {31'd0, tx_done}, 0);
    check("rst_addr", {21'd0, ram_addr}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Hand-computed pins for the model: len=4, id=0 -> checksum 0xB977.
    build_frame(4, 0);
    check("pin_ip_total_len", {16'd0, exp_q[24], exp_q[25]}, 32'h0020);
    check("pin_ip_csum", {16'd0, exp_q[32], exp_q[33]}, 32'hB977);
    check("pin_udp_len", {16'd0, exp_q[46], exp_q[47]}, 32'h000C);
    check("pin_payload", {exp_q[50], exp_q[51], exp_q[52], exp_q[53]}, 32'hDEADBEEF);
    check("pin_frame_len", exp_q.size(), 68 + FCS_N);
`ifdef UDP_TX_FCS_EN
    begin
      logic [7:0] ref_q[$];
      ref_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("pin_crc_check_value", ~crc32(ref_q), 32'hCBF43926);
    end
`endif
    run_frame(4, 0, 1'b0);

    build_frame(0, 1);
    check("pin_len0_csum", {16'd0, exp_q[32], exp_q[33]}, 32'hB97A);
    run_frame(0, 1, 1'b0);

    build_frame(1472, 2);
    check("pin_clamp_total_len", {16'd0, exp_q[24], exp_q[25]}, 32'h05DC);
    run_frame(2000, 2, 1'b0);

    run_frame(20, 3, 1'b1);
    run_frame(5, 4, 1'b0);

    // Reset in the middle of the payload: frame abandoned, ip_id back to 0.
    build_frame(30, 5);
    clear_track();
    start_frame(30, st);
    repeat (58) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_en", {31'd0, gmii_tx_en}, 0);
    check("rst_mid_txd", {24'd0, gmii_txd}, 0);
    check("rst_mid_busy", {31'd0, tx_busy}, 0);
    check("rst_mid_addr", {21'd0, ram_addr}, 0);
    exp_q.delete();
    repeat (80) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);

    run_frame(18, 0, 1'b0);
    run_frame(17, 1, 1'b0);
    run_frame(1, 2, 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
